usfft_result_decoder: RTL
=========================

USFFT_RESULT_DECODER -- requirements
Module: usfft_result_decoder

Interface
REQ-001 Parameter BITWIDTH, default 8: accumulation window is 2^BITWIDTH cycles; result precision.
REQ-002 Parameter NCH, default 8: number of bitstream channels decoded in parallel.
REQ-003 Parameter SKIP, default 2: leading cycles discarded after start, covering upstream butterfly register latency.
REQ-004 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-005 iRstN  input  1  reset, synchronous, active-low.
REQ-006 iClr  input  1  synchronous abort; returns to IDLE and clears counters.
REQ-007 iStart  input  1  single-cycle request to begin one decode window.
REQ-008 iBits  input  NCH  one bitstream bit per channel; order [0..7] = CReal0, CImg0, CReal1, CImg1, DReal0, DImg0, DReal1, DImg1.
REQ-009 iReady  input  1  consumer accepts the result.
REQ-010 oBusy  output  1  high in any state other than IDLE.
REQ-011 oValid  output  1  result available.
REQ-012 oData  output  NCH*(BITWIDTH+1)  per-channel signed two's-complement bipolar result; channel n occupies bits [n*(BITWIDTH+1) +: BITWIDTH+1].

Function
REQ-013 The FSM shall have states IDLE, SKIP, ACCUM and HOLD.
REQ-014 IDLE with iStart=1 shall go to SKIP, or directly to ACCUM when SKIP=0, and clear all channel counters.
REQ-015 SKIP shall last exactly SKIP cycles, ignoring iBits, then go to ACCUM.
REQ-016 ACCUM shall last exactly 2^BITWIDTH cycles, incrementing channel n's count on each cycle where iBits[n]=1.
REQ-017 Each count shall be BITWIDTH+1 bits unsigned (range 0..2^BITWIDTH); no wrap is possible.
REQ-018 On leaving ACCUM, oData channel n shall load count_n - 2^(BITWIDTH-1) (range -2^(BITWIDTH-1)..+2^(BITWIDTH-1)), and the FSM shall enter HOLD.
REQ-019 oValid shall be high exactly while in HOLD; first high cycle is the cycle after the last ACCUM sample.
REQ-020 Start-to-first-oValid latency shall be 1+SKIP+2^BITWIDTH cycles, counted from the iStart edge.
REQ-021 HOLD with iReady=1 shall complete the handshake and return to IDLE the next cycle; oData shall be held stable throughout HOLD regardless of iReady.
REQ-022 oData shall retain the last result after the handshake, until the next ACCUM completes.
REQ-023 iStart in any state other than IDLE shall be ignored, including in the HOLD cycle where iReady=1.
REQ-024 iClr shall take priority over iStart and iReady; in any state it shall force IDLE, clear counters and deassert oValid the next cycle; oData is unchanged.
REQ-025 iClr and iStart together in IDLE shall leave the block in IDLE.

Reset
REQ-026 While iRstN=0 at a clock edge: state IDLE, counters 0, oValid 0, oBusy 0, oData 0.
REQ-027 Reset asserted mid-window shall discard the partial window, and no oValid shall follow.

Structure
REQ-028 A shared package shall hold the FSM state enum, channel index constants (CH_CREAL0..CH_DIMG1), and a function for the window length 2^BITWIDTH.
REQ-029 Per-channel counting and bipolar conversion shall be one sub-module, usfft_stream_counter, instantiated NCH times; the FSM and window/skip counter live in the top.

Verification
REQ-030 BITWIDTH=8, SKIP=2, all iBits=1 during ACCUM -> every channel +128, oValid first high 259 cycles after the iStart edge.
REQ-031 All iBits=0 -> every channel -128; alternating 1/0 -> 0; channel n fed with n*32 ones -> n*32-128.
REQ-032 iReady held low 10 cycles in HOLD -> oValid and oData stable for all 10; iReady=1 -> IDLE next cycle, oBusy=0.
REQ-033 iStart pulsed during SKIP, ACCUM and HOLD -> ignored; exactly one result is produced.
REQ-034 iClr at ACCUM cycle 100 -> IDLE next cycle, no oValid; a fresh iStart then yields a correct full-window result.
REQ-035 iRstN low during ACCUM -> all outputs 0 next edge; the bits sampled during SKIP are shown to be excluded from the count.

Source files
------------

// File: rtl/usfft_result_decoder_pkg.sv
// Shared definitions for the USFFT result decoder: FSM states, channel
// positions within the bitstream bus, and the accumulation window length.
package usfft_result_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    // Bit positions of each butterfly output stream on the iBits bus
    localparam int CH_CREAL0 = 0;
    localparam int CH_CIMG0  = 1;
    localparam int CH_CREAL1 = 2;
    localparam int CH_CIMG1  = 3;
    localparam int CH_DREAL0 = 4;
    localparam int CH_DIMG0  = 5;
    localparam int CH_DREAL1 = 6;
    localparam int CH_DIMG1  = 7;

    function automatic int window_len(input int bitwidth);
        return 1 << bitwidth;
    endfunction

endpackage

// File: rtl/usfft_stream_counter.sv
// Counts the ones of one bitstream over a decode window and converts the
// final count to a signed bipolar value centred on zero.
module usfft_stream_counter
    import usfft_result_decoder_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accumulate,
    input  logic              sample,
    input  logic              load,
    output logic [BITWIDTH:0] result
);

    localparam int                W    = BITWIDTH + 1;
    localparam logic [BITWIDTH:0] HALF = W'(window_len(BITWIDTH) / 2);

    logic [BITWIDTH:0] count;
    logic [BITWIDTH:0] count_next;

    // The last window sample arrives on the same edge as load, so the result
    // is taken from the incremented value; modulo-2^W subtraction yields the
    // two's-complement bipolar value directly, including the full-count case.
    assign count_next = count + W'(sample);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (accumulate) begin
                count <= count_next;
            end
            if (load) begin
                result <= count_next - HALF;
            end
        end
    end

endmodule

// File: rtl/usfft_result_decoder.sv
// Decodes NCH stochastic bitstreams into signed results: optional skip of
// pipeline fill cycles, a 2^BITWIDTH-cycle count window, then a held result.
module usfft_result_decoder
    import usfft_result_decoder_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int NCH      = 8,
    parameter int SKIP     = 2
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iClr,
    input  logic                         iStart,
    input  logic [NCH-1:0]               iBits,
    input  logic                         iReady,
    output logic                         oBusy,
    output logic                         oValid,
    output logic [NCH*(BITWIDTH+1)-1:0]  oData
);

    localparam int W      = BITWIDTH + 1;
    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int CW     = (BITWIDTH > SKIP_W) ? BITWIDTH : SKIP_W;

    localparam logic [CW-1:0] SKIP_LAST = CW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CW-1:0] WIN_LAST  = CW'(window_len(BITWIDTH) - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          clear;
    logic          accumulate;
    logic          load;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear      = 1'b0;
        accumulate = 1'b0;
        load       = 1'b0;

        if (iClr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            clear      = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        state_next = (SKIP == 0) ? ST_ACCUM : ST_SKIP;
                        cnt_next   = '0;
                        clear      = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (cnt == SKIP_LAST) begin
                        state_next = ST_ACCUM;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                ST_ACCUM: begin
                    accumulate = 1'b1;
                    if (cnt == WIN_LAST) begin
                        state_next = ST_HOLD;
                        cnt_next   = '0;
                        load       = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (iReady) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign oBusy  = (state != ST_IDLE);
    assign oValid = (state == ST_HOLD);

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        usfft_stream_counter #(
            .BITWIDTH(BITWIDTH)
        ) u_counter (
            .clk        (iClk),
            .rst_n      (iRstN),
            .clear      (clear),
            .accumulate (accumulate),
            .sample     (iBits[n]),
            .load       (load),
            .result     (oData[n*W +: W])
        );
    end

endmodule
